rom_arbiter: RTL

- Shares one two-port read-only memory between NREQ independent read requesters.
- Each cycle it grants up to two pending requesters, one per ROM port, in round-robin order.
- It captures the returned words and acknowledges each requester with a one-cycle pulse.
- It sits between the CPU fetch, DMA and video engines and the on-chip boot/character ROM.

---
 rtl/rom_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing a two-port ROM between NREQ read requesters.
// Up to two grants per cycle (one per ROM port); each requester acks two cycles after its grant.
//
// state  | meaning
// IDLE   | no access in flight; eligible for a grant when req is high
// ISSUED | address presented to a ROM port last cycle; data arrives this cycle
// ACK    | returned word captured; ack pulses for this one cycle
module rom_arbiter #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 32,
    parameter int NREQ   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*AWIDTH-1:0]   adr_i,
    output logic [NREQ-1:0]          ack_o,
    output logic [NREQ*DWIDTH-1:0]   dat_o,
    output logic [AWIDTH-1:0]        rom0_adr_o,
    input  logic [DWIDTH-1:0]        rom0_dat_i,
    output logic [AWIDTH-1:0]        rom1_adr_o,
    input  logic [DWIDTH-1:0]        rom1_dat_i,
    output logic                     busy_o
);

    localparam int RRW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUED = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t              state      [NREQ];
    state_t              state_next [NREQ];
    logic [NREQ-1:0]     tag;
    logic [NREQ*DWIDTH-1:0] dat;
    logic [RRW-1:0]      rr;
    logic [RRW-1:0]      rr_next;

    logic                grant0_vld;
    logic                grant1_vld;
    logic [RRW-1:0]      grant0_idx;
    logic [RRW-1:0]      grant1_idx;
    logic [RRW-1:0]      last_idx;
    logic [RRW-1:0]      idx;
    logic [RRW:0]        sum;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     grant_port;

    // Scan from rr with wrap; first eligible goes to port 0, second to port 1.
    always_comb begin
        grant0_vld = 1'b0;
        grant1_vld = 1'b0;
        grant0_idx = '0;
        grant1_idx = '0;
        grant      = '0;
        grant_port = '0;
        sum        = '0;
        idx        = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr} + (RRW+1)'(k);
            if (sum >= (RRW+1)'(NREQ))
                sum = sum - (RRW+1)'(NREQ);
            idx = sum[RRW-1:0];
            if (req_i[idx] && state[idx] == IDLE) begin
                if (!grant0_vld) begin
                    grant0_vld = 1'b1;
                    grant0_idx = idx;
                    grant[idx] = 1'b1;
                end else if (!grant1_vld) begin
                    grant1_vld      = 1'b1;
                    grant1_idx      = idx;
                    grant[idx]      = 1'b1;
                    grant_port[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        last_idx = grant1_vld ? grant1_idx : grant0_idx;
        rr_next  = rr;
        if (grant0_vld) begin
            if (last_idx == RRW'(NREQ-1))
                rr_next = '0;
            else
                rr_next = last_idx + RRW'(1);
        end
    end

    always_comb begin
        rom0_adr_o = '0;
        rom1_adr_o = '0;
        if (grant0_vld)
            rom0_adr_o = adr_i[int'(grant0_idx)*AWIDTH +: AWIDTH];
        if (grant1_vld)
            rom1_adr_o = adr_i[int'(grant1_idx)*AWIDTH +: AWIDTH];
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            state_next[i] = state[i];
            case (state[i])
                IDLE:    if (grant[i]) state_next[i] = ISSUED;
                ISSUED:  state_next[i] = ACK;
                ACK:     state_next[i] = IDLE;
                default: state_next[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr  <= '0;
            tag <= '0;
            dat <= '0;
            for (int i = 0; i < NREQ; i++)
                state[i] <= IDLE;
        end else begin
            rr <= rr_next;
            for (int i = 0; i < NREQ; i++) begin
                state[i] <= state_next[i];
                if (state[i] == IDLE && grant[i])
                    tag[i] <= grant_port[i];
                // The port tag recorded at grant picks which ROM port carries this word.
                if (state[i] == ISSUED)
                    dat[i*DWIDTH +: DWIDTH] <= tag[i] ? rom1_dat_i : rom0_dat_i;
            end
        end
    end

    always_comb begin
        ack_o  = '0;
        busy_o = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ack_o[i] = (state[i] == ACK);
            if (state[i] != IDLE)
                busy_o = 1'b1;
        end
    end

    assign dat_o = dat;

endmodule
